// File: rtl/fifo_stream_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_drain
// Purpose  : Drains words from a synchronous FIFO read port (one-cycle
//            registered read latency) and presents them as a valid/ready
//            stream. A 2-entry output buffer hides the read latency, so
//            one word per clock is sustained. Also counts completed
//            handshakes and supports a synchronous flush.
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            flush          - discard buffered and in-flight words
//            fifo_empty     - FIFO empty flag
//            fifo_data      - FIFO data_out, valid the cycle after fifo_ren
//            fifo_ren       - FIFO read enable (combinational)
//            m_valid/m_ready/m_data - output stream
//            xfer_cnt       - count of completed handshakes (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_drain #(
   parameter int DW = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          fifo_empty,
   input  logic [DW-1:0] fifo_data,
   output logic          fifo_ren,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic [CW-1:0] xfer_cnt
);

   logic [1:0]    r_occ;     // words held in the output buffer
   logic          r_inf;     // a read was issued last cycle; data arrives now
   logic [DW-1:0] r_head;
   logic [DW-1:0] r_tail;
   logic [CW-1:0] r_cnt;

   logic          w_pop;
   logic          w_cap;
   logic [1:0]    w_after_pop;
   logic [2:0]    w_pending;

   assign w_pop       = (r_occ != 2'd0) & m_ready;
   assign w_cap       = r_inf & ~flush;
   assign w_after_pop = r_occ - {1'b0, w_pop};

   // Words owned by this stage after this cycle's pop: buffered plus the
   // one returning from the FIFO. A new read is only allowed if it will
   // still fit in the buffer when its data returns.
   assign w_pending = {1'b0, r_occ} + {2'b00, r_inf} - {2'b00, w_pop};
   assign fifo_ren  = rst_n & ~fifo_empty & ~flush & (w_pending < 3'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_occ  <= 2'd0;
         r_inf  <= 1'b0;
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else begin
         r_inf <= fifo_ren;

         if (w_pop)
            r_cnt <= r_cnt + 1'b1;

         if (flush)
            r_occ <= 2'd0;
         else
            r_occ <= r_occ + {1'b0, w_cap} - {1'b0, w_pop};

         // Popping a full buffer advances the tail into the head.
         if (w_pop && (r_occ == 2'd2))
            r_head <= r_tail;

         // Returning data lands in the head only if the buffer is empty
         // once this cycle's pop has been taken into account.
         if (w_cap) begin
            if (w_after_pop == 2'd0)
               r_head <= fifo_data;
            else
               r_tail <= fifo_data;
         end
      end
   end

   assign m_valid  = (r_occ != 2'd0);
   assign m_data   = r_head;
   assign xfer_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_drain
// Purpose  : Self-checking bench for fifo_stream_drain. A FIFO model feeds
//            the DUT; pushed words go into an expected-word queue and a
//            monitor pops and compares each delivered word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_drain;

   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          m_ready = 1'b0;
   logic          fifo_empty;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_ren;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic [CW-1:0] xfer_cnt;

   // FIFO model: storage plus read/write pointers, registered read.
   logic [DW-1:0] fmem [0:8191];
   logic [12:0]   wp = '0;
   logic [12:0]   rp = '0;

   int            vectors = 0;
   int            miscompares = 0;

   // Scoreboard: words pushed into the FIFO, in order, not yet delivered.
   logic [DW-1:0] exp_q [$];
   int            outstanding = 0;   // words read from FIFO, not yet delivered
   int            exp_cnt = 0;
   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_data = '0;

   fifo_stream_drain #(.DW(DW), .CW(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_ren   (fifo_ren),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .xfer_cnt   (xfer_cnt)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (wp == rp);

   always @(posedge clk) begin
      if (fifo_ren) begin
         fifo_data <= fmem[rp];
         rp        <= rp + 13'd1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      fmem[wp] = d;
      wp       = wp + 13'd1;
      exp_q.push_back(d);
   endtask

   task automatic drop_outstanding();
      while (outstanding > 0) begin
         if (exp_q.size() > 0)
            void'(exp_q.pop_front());
         outstanding--;
      end
   endtask

   // Monitor: samples on the falling edge, mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_ren", fifo_ren, 0);
         chk("reset_valid", m_valid, 0);
         drop_outstanding();
         exp_cnt   = 0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_data);
         end
         chk("xfer_cnt", xfer_cnt, exp_cnt);
         chk("ren_while_empty", fifo_ren & fifo_empty, 0);
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0)
               chk("sb_underflow", exp_q.size(), 1);
            else
               chk("stream_data", m_data, exp_q.pop_front());
            outstanding--;
            exp_cnt = (exp_cnt + 1) % (1 << CW);
         end
         if (fifo_ren)
            outstanding++;
         if (flush)
            drop_outstanding();
         chk("occupancy_le2", (outstanding > 2), 0);
         prev_hold = m_valid && !m_ready && !flush;
         prev_data = m_data;
      end
   end

   initial begin
      int t_ren, t_val, t_last, nren, k;
      logic saw_wrap;
      logic [CW-1:0] pcnt;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_xfer_cnt", xfer_cnt, 0);
      chk("rst_fifo_ren", fifo_ren, 0);
      step();
      rst_n = 1'b1;

      // Streaming: latency, back-to-back delivery, count
      step();
      m_ready = 1'b1;
      push(8'h11); push(8'h22); push(8'h33);
      t_ren = -1; t_val = -1; t_last = -1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (fifo_ren && t_ren < 0) t_ren = c;
         if (m_valid) begin
            if (t_val < 0) t_val = c;
            t_last = c;
         end
      end
      chk("stream_latency", t_val - t_ren, 2);
      chk("stream_contiguous", t_last - t_val, 2);
      chk("stream_cnt", xfer_cnt, 3);

      // Backpressure: two reads only, head word held
      step();
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
      nren = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (fifo_ren) nren++;
      end
      chk("bp_ren_pulses", nren, 2);
      chk("bp_valid", m_valid, 1);
      chk("bp_head", m_data, 8'hA0);
      step();
      m_ready = 1'b1;
      repeat (12) @(negedge clk);
      chk("bp_cnt", xfer_cnt, 8);

      // Empty guard with toggling ready
      for (int c = 0; c < 8; c++) begin
         step();
         m_ready = c[0];
      end
      @(negedge clk);
      chk("empty_valid", m_valid, 0);
      chk("empty_ren", fifo_ren, 0);

      // Flush with one buffered word and one in flight
      step();
      m_ready = 1'b0;
      push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
      k = 0;
      @(negedge clk);
      while (!fifo_ren && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("flush_first_ren", fifo_ren, 1);
      step();
      step();
      flush = 1'b1;
      @(negedge clk);
      chk("flush_pre_valid", m_valid, 1);
      chk("flush_ren_low", fifo_ren, 0);
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_valid_low", m_valid, 0);
      step();
      m_ready = 1'b1;
      k = 0;
      @(negedge clk);
      while (!m_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("flush_next_word", m_data, 8'hB2);
      repeat (10) @(negedge clk);

      // Counter wrap (CW=4): 17 words from a cleared counter
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
      saw_wrap = 1'b0;
      pcnt = xfer_cnt;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (pcnt == 4'd15 && xfer_cnt == 4'd0) saw_wrap = 1'b1;
         pcnt = xfer_cnt;
      end
      chk("wrap_seen", saw_wrap, 1);
      chk("wrap_final", xfer_cnt, 1);

      // Asynchronous reset mid-stream
      step();
      for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", m_valid, 0);
      chk("async_cnt", xfer_cnt, 0);
      chk("async_ren", fifo_ren, 0);
      step();
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("async_resume_cnt_nonzero", (xfer_cnt != 0), 1);

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         step();
         m_ready = ($urandom_range(0, 3) != 0);
         flush   = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 1) == 1 && (wp - rp) < 13'd30)
            push(8'($urandom));
      end
      step();
      flush   = 1'b0;
      m_ready = 1'b1;
      k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("drain_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
